// File: rtl/instr_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_pkg
//  Description : Opcode map, ALU function codes, instruction classes and the
//                control-strobe record shared by the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_decode_pkg;

    // Opcode map (low four opcode bits; wider opcodes with any upper bit set
    // are outside the map and decode as illegal)
    localparam int         MAP_OPC_W   = 4;
    localparam logic [3:0] OPC_ADD     = 4'd0;
    localparam logic [3:0] OPC_SUB     = 4'd1;
    localparam logic [3:0] OPC_AND     = 4'd2;
    localparam logic [3:0] OPC_OR      = 4'd3;
    localparam logic [3:0] OPC_XOR     = 4'd4;
    localparam logic [3:0] OPC_SLL     = 4'd5;
    localparam logic [3:0] OPC_SRL     = 4'd6;
    localparam logic [3:0] OPC_MOV     = 4'd7;
    localparam logic [3:0] OPC_ADDI    = 4'd8;
    localparam logic [3:0] OPC_LOAD    = 4'd9;
    localparam logic [3:0] OPC_STORE   = 4'd10;
    localparam logic [3:0] OPC_LI      = 4'd11;
    localparam logic [3:0] OPC_JMP     = 4'd12;
    localparam logic [3:0] OPC_BEQZ    = 4'd13;
    localparam logic [3:0] OPC_HALT    = 4'd14;
    localparam logic [3:0] OPC_ILLEGAL = 4'd15;

    // ALU function codes (R-type opcodes map one-to-one onto these)
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_MOV = 3'd7;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_J   = 2'd2,
        CLS_SYS = 2'd3
    } instr_class_e;

    // Control strobes carried in every decoded bundle
    typedef struct packed {
        logic [2:0] alu_op;
        logic       rd_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       is_jump;
        logic       is_branch;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Bundle layout: {opcode, dest, src2, imm_ext, ctrl}
    function automatic int bundle_width(input int opc_w, input int reg_w, input int data_w);
        return opc_w + 2 * reg_w + data_w + CTRL_W;
    endfunction

    function automatic instr_class_e classify(input logic [3:0] op);
        if (op <= OPC_MOV)       return CLS_R;
        else if (op <= OPC_LI)   return CLS_I;
        else if (op <= OPC_BEQZ) return CLS_J;
        else                     return CLS_SYS;
    endfunction

    // Arithmetic and memory I-types carry signed offsets; LI/JMP/BEQZ are unsigned
    function automatic logic is_sign_ext(input logic [3:0] op);
        return (op == OPC_ADDI) || (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [3:0] op, input logic in_map);
        ctrl_t c;
        c = '0;
        if (!in_map) begin
            c.illegal = 1'b1;
        end else begin
            case (classify(op))
                CLS_R: begin
                    c.alu_op = op[2:0];
                    c.rd_we  = 1'b1;
                end
                CLS_I: begin
                    case (op)
                        OPC_ADDI:  begin c.rd_we = 1'b1; c.alu_op = ALU_ADD; end
                        OPC_LOAD:  begin c.rd_we = 1'b1; c.mem_rd = 1'b1; end
                        OPC_STORE: c.mem_wr = 1'b1;
                        default:   begin c.rd_we = 1'b1; c.alu_op = ALU_MOV; end
                    endcase
                end
                CLS_J: begin
                    if (op == OPC_JMP) c.is_jump   = 1'b1;
                    else               c.is_branch = 1'b1;
                end
                default: begin
                    // HALT raises no strobes; the last code is reserved
                    c.illegal = (op == OPC_ILLEGAL);
                end
            endcase
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode_stage_skid_buffer2.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer2
//  Description : Two-entry valid/ready skid buffer with registered ready,
//                synchronous flush and an external block request.
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             block_next,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             head_valid, tail_valid, ready_q;
    logic [WIDTH-1:0] head_data, tail_data;
    logic             push, pop;
    logic             head_valid_n, tail_valid_n;
    logic             head_from_in, head_from_tail, tail_from_in;

    assign push      = in_valid && ready_q && !flush;
    assign pop       = head_valid && out_ready && !flush;
    assign in_ready  = ready_q;
    assign out_valid = head_valid;
    assign out_data  = head_data;

    // Occupancy transitions; the tail only fills when the head is held
    always_comb begin
        head_valid_n   = head_valid;
        tail_valid_n   = tail_valid;
        head_from_in   = 1'b0;
        head_from_tail = 1'b0;
        tail_from_in   = 1'b0;
        if (flush) begin
            head_valid_n = 1'b0;
            tail_valid_n = 1'b0;
        end else if (pop) begin
            if (tail_valid) begin
                head_from_tail = 1'b1;
                tail_valid_n   = 1'b0;
            end else if (push) begin
                head_from_in = 1'b1;
            end else begin
                head_valid_n = 1'b0;
            end
        end else if (push) begin
            if (head_valid) begin
                tail_from_in = 1'b1;
                tail_valid_n = 1'b1;
            end else begin
                head_from_in = 1'b1;
                head_valid_n = 1'b1;
            end
        end
    end

    // Entry valids and the registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            head_valid <= head_valid_n;
            tail_valid <= tail_valid_n;
            ready_q    <= !tail_valid_n && !block_next;
        end
    end

    // Entry payloads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            tail_data <= '0;
        end else begin
            if (head_from_tail)    head_data <= tail_data;
            else if (head_from_in) head_data <= in_data;
            if (tail_from_in)      tail_data <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage
//  Description : Registered decode stage: field split, class decode, immediate
//                extension, skid-buffered handshake, flush, sticky halt and a
//                retired-bundle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage #(
    parameter int INSTR_W = 10,
    parameter int OPC_W   = 4,
    parameter int REG_W   = 3,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   dest,
    output logic [REG_W-1:0]   src1,
    output logic [REG_W-1:0]   src2,
    output logic [DATA_W-1:0]  imm_ext,
    output logic [2:0]         alu_op,
    output logic               rd_we,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               is_jump,
    output logic               is_branch,
    output logic               illegal,
    output logic               halted,
    output logic [CNT_W-1:0]   decode_count
);
    import instr_decode_pkg::*;

    localparam int IMM_W    = INSTR_W - OPC_W;
    localparam int BUNDLE_W = bundle_width(OPC_W, REG_W, DATA_W);

    logic [OPC_W-1:0]    dec_opcode;
    logic [REG_W-1:0]    dec_dest, dec_src2;
    logic [IMM_W-1:0]    imm_field;
    logic [DATA_W-1:0]   dec_imm;
    logic [3:0]          opc_lo;
    logic                opc_in_map;
    ctrl_t               dec_ctrl, head_ctrl;
    logic                dec_halt, halt_accept, pop;
    logic [BUNDLE_W-1:0] dec_bundle, head_bundle;

    assign dec_opcode = instruction[INSTR_W-1 -: OPC_W];
    assign dec_dest   = instruction[2*REG_W-1:REG_W];
    assign dec_src2   = instruction[REG_W-1:0];
    assign imm_field  = instruction[IMM_W-1:0];

    // Opcodes wider than the map are only legal when the extra bits are zero
    generate
        if (OPC_W > MAP_OPC_W) begin : g_wide_opcode
            assign opc_lo     = dec_opcode[3:0];
            assign opc_in_map = ~|dec_opcode[OPC_W-1:MAP_OPC_W];
        end else begin : g_map_opcode
            assign opc_lo     = dec_opcode[3:0];
            assign opc_in_map = 1'b1;
        end
    endgenerate

    assign dec_ctrl = decode_ctrl(opc_lo, opc_in_map);
    assign dec_halt = opc_in_map && (opc_lo == OPC_HALT);

    // Immediate extension chosen by opcode
    always_comb begin
        dec_imm = DATA_W'(imm_field);
        if (opc_in_map && is_sign_ext(opc_lo)) begin
            dec_imm = DATA_W'($signed(imm_field));
        end
    end

    assign dec_bundle = {dec_opcode, dec_dest, dec_src2, dec_imm, dec_ctrl};

    // A HALT that is actually taken in (not flushed) blocks all later input
    assign halt_accept = in_valid && in_ready && !flush && dec_halt;
    assign pop         = out_valid && out_ready && !flush;

    skid_buffer2 #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .block_next (halted || halt_accept),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (dec_bundle),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (head_bundle)
    );

    assign {opcode, dest, src2, imm_ext, head_ctrl} = head_bundle;
    assign src1      = dest;
    assign alu_op    = head_ctrl.alu_op;
    assign rd_we     = head_ctrl.rd_we;
    assign mem_rd    = head_ctrl.mem_rd;
    assign mem_wr    = head_ctrl.mem_wr;
    assign is_jump   = head_ctrl.is_jump;
    assign is_branch = head_ctrl.is_branch;
    assign illegal   = head_ctrl.illegal;

    // Sticky halt, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           halted <= 1'b0;
        else if (halt_accept) halted <= 1'b1;
    end

    // Count bundles handed downstream (wraps naturally)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   decode_count <= '0;
        else if (pop) decode_count <= decode_count + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_instr_decode_stage
//  Description : Self-checking bench for instr_decode_stage (vector table,
//                directed handshake sequences, randomized model comparison).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

    localparam int INSTR_W = 10;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 3;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction = '0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   dest, src1, src2;
    logic [DATA_W-1:0]  imm_ext;
    logic [2:0]         alu_op;
    logic               rd_we, mem_rd, mem_wr, is_jump, is_branch, illegal, halted;
    logic [CNT_W-1:0]   decode_count;

    always #5 clk = ~clk;

    instr_decode_stage #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W),
        .REG_W   (REG_W),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .opcode       (opcode),
        .dest         (dest),
        .src1         (src1),
        .src2         (src2),
        .imm_ext      (imm_ext),
        .alu_op       (alu_op),
        .rd_we        (rd_we),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .is_jump      (is_jump),
        .is_branch    (is_branch),
        .illegal      (illegal),
        .halted       (halted),
        .decode_count (decode_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Compare the presented bundle; strobes are {rd_we, mem_rd, mem_wr, jump, branch}
    task automatic check_out(input string tag, input logic [3:0] op, input logic [2:0] dst,
                             input logic [2:0] s2, input logic [15:0] imm, input bit ck_imm,
                             input logic [2:0] alu, input bit ck_alu, input logic [4:0] strb,
                             input logic ill);
        chk({tag, "_valid"},  32'(out_valid), 32'd1);
        chk({tag, "_opcode"}, 32'(opcode), 32'(op));
        chk({tag, "_dest"},   32'(dest), 32'(dst));
        chk({tag, "_src1"},   32'(src1), 32'(dst));
        chk({tag, "_src2"},   32'(src2), 32'(s2));
        if (ck_imm) chk({tag, "_imm"}, 32'(imm_ext), 32'(imm));
        if (ck_alu) chk({tag, "_alu"}, 32'(alu_op), 32'(alu));
        chk({tag, "_strobes"}, 32'({rd_we, mem_rd, mem_wr, is_jump, is_branch}), 32'(strb));
        chk({tag, "_illegal"}, 32'(illegal), 32'(ill));
    endtask

    // Reference decode straight from the opcode table, using integer arithmetic
    typedef struct {
        logic [3:0]  op;
        logic [2:0]  dst, s2;
        logic [15:0] imm;
        bit          ck_imm;
        logic [2:0]  alu;
        bit          ck_alu;
        logic [4:0]  strb;
        logic        ill;
    } exp_t;

    function automatic exp_t model(input logic [INSTR_W-1:0] ins);
        exp_t e;
        int op   = int'(ins[9:6]);
        int imm6 = int'(ins[5:0]);
        int simm = (imm6 >= 32) ? imm6 - 64 : imm6;
        e.op = ins[9:6]; e.dst = ins[5:3]; e.s2 = ins[2:0];
        e.imm = 16'(imm6); e.ck_imm = 0; e.alu = 3'd0; e.ck_alu = 0; e.strb = 5'b0; e.ill = 1'b0;
        if (op < 8) begin
            e.strb = 5'b10000; e.alu = 3'(op); e.ck_alu = 1;
        end else begin
            case (op)
                8:  begin e.strb = 5'b10000; e.alu = 3'd0; e.ck_alu = 1; e.imm = 16'(simm); e.ck_imm = 1; end
                9:  begin e.strb = 5'b11000; e.imm = 16'(simm); e.ck_imm = 1; end
                10: begin e.strb = 5'b00100; e.imm = 16'(simm); e.ck_imm = 1; end
                11: begin e.strb = 5'b10000; e.alu = 3'd7; e.ck_alu = 1; e.ck_imm = 1; end
                12: begin e.strb = 5'b00010; e.ck_imm = 1; end
                13: begin e.strb = 5'b00001; e.ck_imm = 1; end
                15: e.ill = 1'b1;
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic check_model(input string tag, input logic [INSTR_W-1:0] ins);
        exp_t e;
        e = model(ins);
        check_out(tag, e.op, e.dst, e.s2, e.imm, e.ck_imm, e.alu, e.ck_alu, e.strb, e.ill);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_halted",    32'(halted), 32'd0);
        chk("rst_count",     32'(decode_count), 32'd0);
        chk("rst_bundle",    32'({opcode, dest, src2, imm_ext}), 32'd0);
        chk("rst_strobes",   32'({alu_op, rd_we, mem_rd, mem_wr, is_jump, is_branch, illegal}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        exp_cnt = '0;
    endtask

    // Hand-written vectors: instruction and its expected decode
    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [3:0]         op;
        logic [2:0]         dst, s2;
        logic [15:0]        imm;
        bit                 ck_imm;
        logic [2:0]         alu;
        bit                 ck_alu;
        logic [4:0]         strb;
        logic               ill;
    } vec_t;

    vec_t vecs[10];
    logic [INSTR_W-1:0] q[$];

    initial begin
        vecs[0] = '{10'b0001_011_101, 4'd1,  3'd3, 3'd5, 16'h0000, 0, 3'd1, 1, 5'b10000, 1'b0};
        vecs[1] = '{10'b1000_111111,  4'd8,  3'd7, 3'd7, 16'hFFFF, 1, 3'd0, 1, 5'b10000, 1'b0};
        vecs[2] = '{10'b1011_111111,  4'd11, 3'd7, 3'd7, 16'h003F, 1, 3'd7, 1, 5'b10000, 1'b0};
        vecs[3] = '{10'b1100_101010,  4'd12, 3'd5, 3'd2, 16'h002A, 1, 3'd0, 0, 5'b00010, 1'b0};
        vecs[4] = '{10'b1111_000000,  4'd15, 3'd0, 3'd0, 16'h0000, 0, 3'd0, 0, 5'b00000, 1'b1};
        vecs[5] = '{10'b1001_100000,  4'd9,  3'd4, 3'd0, 16'hFFE0, 1, 3'd0, 0, 5'b11000, 1'b0};
        vecs[6] = '{10'b1010_011111,  4'd10, 3'd3, 3'd7, 16'h001F, 1, 3'd0, 0, 5'b00100, 1'b0};
        vecs[7] = '{10'b1101_110001,  4'd13, 3'd6, 3'd1, 16'h0031, 1, 3'd0, 0, 5'b00001, 1'b0};
        vecs[8] = '{10'b0100_010_110, 4'd4,  3'd2, 3'd6, 16'h0000, 0, 3'd4, 1, 5'b10000, 1'b0};
        vecs[9] = '{10'b0111_001_001, 4'd7,  3'd1, 3'd1, 16'h0000, 0, 3'd7, 1, 5'b10000, 1'b0};

        do_reset();

        // Table vectors, one at a time with the consumer ready
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; instruction = vecs[i].instr; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].dst, vecs[i].s2, vecs[i].imm,
                      vecs[i].ck_imm, vecs[i].alu, vecs[i].ck_alu, vecs[i].strb, vecs[i].ill);
            @(negedge clk);
            exp_cnt++;
            chk($sformatf("vec%0d_count", i), 32'(decode_count), 32'(exp_cnt));
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: three pushes against a stalled consumer
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instruction = 10'b0000_001_001;
        @(negedge clk);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        instruction = 10'b0011_010_010;
        @(negedge clk);
        chk("bp_ready2", 32'(in_ready), 32'd0);
        chk("bp_valid",  32'(out_valid), 32'd1);
        chk("bp_headA",  32'({opcode, dest}), 32'({4'd0, 3'd1}));
        instruction = 10'b0010_011_011;
        @(negedge clk);
        chk("bp_ready3", 32'(in_ready), 32'd0);
        chk("bp_stable", 32'({opcode, dest, src2}), 32'({4'd0, 3'd1, 3'd1}));
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        chk("bp_headB",  32'({out_valid, opcode, dest}), 32'({1'b1, 4'd3, 3'd2}));
        chk("bp_ready4", 32'(in_ready), 32'd1);
        chk("bp_cnt1",   32'(decode_count), 32'(exp_cnt));
        @(negedge clk);
        exp_cnt++;
        chk("bp_headC",  32'({out_valid, opcode, dest}), 32'({1'b1, 4'd2, 3'd3}));
        in_valid = 1'b0;
        @(negedge clk);
        exp_cnt++;
        chk("bp_empty",  32'(out_valid), 32'd0);
        chk("bp_cnt3",   32'(decode_count), 32'(exp_cnt));

        // Randomized traffic against a queue model (no HALT)
        q.delete();
        for (int i = 0; i < 400; i++) begin
            logic [INSTR_W-1:0] ins;
            bit do_pop, do_push;
            @(negedge clk);
            chk("rnd_in_ready",  32'(in_ready), 32'(q.size() < 2));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_count",     32'(decode_count), 32'(exp_cnt));
            if (q.size() > 0) check_model("rnd", q[0]);
            ins = INSTR_W'($urandom);
            if (ins[9:6] == 4'd14) ins[9:6] = 4'd0;
            instruction = ins;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            do_pop  = out_ready && (q.size() > 0);
            do_push = in_valid && (q.size() < 2);
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) begin
                    void'(q.pop_front());
                    exp_cnt++;
                end
                if (do_push) q.push_back(ins);
            end
        end
        @(negedge clk);
        chk("rnd_final_count", 32'(decode_count), 32'(exp_cnt));
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("rnd_flushed", 32'(out_valid), 32'd0);

        // Flush with both entries full, coincident push and pop
        @(negedge clk);
        in_valid = 1'b1; instruction = 10'b0001_001_001;
        @(negedge clk);
        instruction = 10'b0001_010_010;
        @(negedge clk);
        chk("fl_full_valid", 32'(out_valid), 32'd1);
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; out_ready = 1'b1; instruction = 10'b0001_011_011;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_count",     32'(decode_count), 32'(exp_cnt));
        chk("fl_in_ready",  32'(in_ready), 32'd1);
        @(negedge clk);
        chk("fl_dropped",   32'(out_valid), 32'd0);

        // HALT followed by continuous input
        in_valid = 1'b1; instruction = 10'b1110_000000; out_ready = 1'b1;
        @(negedge clk);
        chk("halt_set",      32'(halted), 32'd1);
        chk("halt_ready",    32'(in_ready), 32'd0);
        chk("halt_bundle",   32'({out_valid, opcode}), 32'({1'b1, 4'd14}));
        chk("halt_strobes",  32'({rd_we, mem_rd, mem_wr, is_jump, is_branch, illegal}), 32'd0);
        instruction = 10'b0000_001_010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) exp_cnt++;
            chk($sformatf("halt_hold%0d_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("halt_hold%0d_valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("halt_hold%0d_count", i), 32'(decode_count), 32'(exp_cnt));
        end
        chk("halt_sticky", 32'(halted), 32'd1);

        // Reset clears halt; then an asynchronous reset mid-stream
        do_reset();
        in_valid = 1'b1; instruction = 10'b0000_001_010; out_ready = 1'b1;
        @(negedge clk);
        instruction = 10'b1100_101010;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("ar_pre_count", 32'(decode_count), 32'd1);
        chk("ar_pre_jump",  32'({out_valid, opcode, is_jump}), 32'({1'b1, 4'd12, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid",  32'(out_valid), 32'd0);
        chk("ar_count",  32'(decode_count), 32'd0);
        chk("ar_bundle", 32'({opcode, imm_ext, is_jump, halted}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Parametrised, registered instruction-decode pipeline stage placed between fetch and execute.
- Splits an INSTR_W-bit instruction into opcode and register fields, and classifies it as R, I, J or SYS type.
- Produces sign- or zero-extended immediates, control strobes and an illegal-opcode flag.
- Valid/ready handshake on both sides, through a 2-entry skid buffer, so IN_READY is registered; also supports flush, sticky halt and a retired-instruction counter.

Parameters:
- INSTR_W, 10: instruction width. Must satisfy INSTR_W-OPC_W >= 2*REG_W.
- OPC_W, 4: opcode width; opcode is INSTRUCTION[INSTR_W-1 -: OPC_W].
- REG_W, 3: register index width.
- DATA_W, 16: width of the extended immediate; must be >= INSTR_W-OPC_W.
- CNT_W, 16: width of the retired-decode counter.

Ports:
- CLK, in, 1: clock; all state updates on the rising edge.
- RST_N, in, 1: reset, asynchronous and active-low.
- IN_VALID, in, 1: instruction valid.
- IN_READY, out, 1: stage can accept an instruction.
- INSTRUCTION, in, INSTR_W: raw instruction.
- FLUSH, in, 1: discard all buffered instructions.
- OUT_VALID, out, 1: decoded bundle valid.
- OUT_READY, in, 1: downstream accepts the bundle.
- OPCODE, out, OPC_W: opcode field.
- DEST, out, REG_W: bits [2*REG_W-1:REG_W].
- SRC1, out, REG_W: same bits as DEST.
- SRC2, out, REG_W: bits [REG_W-1:0].
- IMM_EXT, out, DATA_W: extended immediate field [INSTR_W-OPC_W-1:0].
- ALU_OP, out, 3: ALU function.
- RD_WE, out, 1: register write.
- MEM_RD, out, 1: load.
- MEM_WR, out, 1: store.
- IS_JUMP, out, 1: jump.
- IS_BRANCH, out, 1: branch.
- ILLEGAL, out, 1: reserved opcode.
- HALTED, out, 1: sticky halt.
- DECODE_COUNT, out, CNT_W: count of bundles handed downstream.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Both skid entries invalid; HALTED=0; DECODE_COUNT=0.
  - OUT_VALID=0; IN_READY=1 from the first edge after release.
  - All bundle outputs = 0.
- Opcode map (package constants):
  - 0-7: R-type ADD, SUB, AND, OR, XOR, SLL, SRL, MOV. ALU_OP=opcode[2:0], RD_WE=1.
  - 8 ADDI: RD_WE=1, ALU_OP=ADD, IMM_EXT sign-extended.
  - 9 LOAD: RD_WE=1, MEM_RD=1, sign-extended.
  - 10 STORE: MEM_WR=1, sign-extended.
  - 11 LI: RD_WE=1, ALU_OP=MOV, zero-extended.
  - 12 JMP: IS_JUMP=1, zero-extended address.
  - 13 BEQZ: IS_BRANCH=1, zero-extended.
  - 14 HALT.
  - 15: ILLEGAL=1, all strobes 0.
  - Opcodes beyond the map (OPC_W>4) are ILLEGAL.
- Datapath:
  - Decode is combinational on input, registered into the skid buffer.
  - Latency is 1 cycle: accepted at edge N, OUT_VALID=1 after edge N.
- Handshake:
  - Transfer occurs when VALID&&READY at an edge.
  - IN_READY=!second_entry_full && !HALTED (registered).
  - Outputs are driven from the head entry and remain stable while OUT_VALID&&!OUT_READY.
  - Full throughput of 1/cycle when OUT_READY=1.
  - Simultaneous push and pop at occupancy 1 keeps occupancy 1.
  - A push at occupancy 2 cannot occur.
- HALT:
  - Its bundle is delivered normally.
  - HALTED sets on the cycle the HALT is accepted at input; IN_READY=0 from the next cycle.
  - HALTED clears only on reset.
- FLUSH has priority over push and pop in the same cycle:
  - Both entries are invalidated; OUT_VALID=0 next cycle.
  - The coincident input is dropped and the coincident output does not count.
  - HALTED is unaffected.
- DECODE_COUNT increments on each OUT_VALID&&OUT_READY and wraps modulo 2^CNT_W.

Decomposition:
- Package instr_decode_pkg: opcode localparams, ALU_OP codes, instruction-class enum (R/I/J/SYS), and the bundle struct/width constant.
- Sub-module skid_buffer2 (width-parametrised, 2 entries, registered ready) holds the decoded bundle.
- The decode logic stays in the top level.

Test Plan:
1. Reset, then INSTRUCTION=10'b0001_011_101 (SUB) with OUT_READY=1 → next cycle OUT_VALID=1, OPCODE=1, DEST=SRC1=3, SRC2=5, RD_WE=1, ALU_OP=1; DECODE_COUNT=1.
2. ADDI 10'b1000_111111 → IMM_EXT=16'hFFFF. LI 10'b1011_111111 → IMM_EXT=16'h003F. JMP 10'b1100_101010 → IS_JUMP=1, IMM_EXT=16'h002A.
3. Backpressure: hold OUT_READY=0, push 3 instructions → IN_READY drops after 2 accepted; outputs stable. Release → both delivered in order on consecutive cycles, the third is accepted, and no instruction is lost or duplicated.
4. Opcode 15 → ILLEGAL=1, RD_WE=MEM_RD=MEM_WR=IS_JUMP=IS_BRANCH=0.
5. HALT followed by continuous IN_VALID → HALT bundle delivered, HALTED=1, IN_READY stays 0 until RST_N pulse.
6. Two entries full, assert FLUSH with IN_VALID=1 and OUT_READY=1 → next cycle OUT_VALID=0, count unchanged, IN_READY=1. Separately, assert RST_N low mid-stream → outputs cleared immediately without a clock.
